// File: rtl/score_pkg.sv
// Shared constants for the four-digit seven-segment scan multiplexer.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package score_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD to active-low seven-segment decode; non-BCD codes show a dash.
module seven_seg_decoder
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display_mux.sv
// Four-digit seven-segment scan multiplexer with anode-off guard time,
// per-frame input snapshot and leading-zero blanking.
//
// state    | meaning
// ST_BLANK | all anodes off; guard counter running, or idle after reset
// ST_DRIVE | anode [index] on, shadow digit decoded onto seg/dp
module score_display_mux
  import score_pkg::*;
#(
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        clk_1kHz,
  input  logic [15:0] digits_bcd,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

  logic sync_1, sync_2, sync_3;
  logic scan_tick, wrap;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0] index, index_next;

  logic [NUM_DIGITS-1:0][3:0] shadow_digits, digits_next;
  logic [NUM_DIGITS-1:0]      shadow_dp, dp_mask_next;
  logic                       shadow_lz, lz_next;

  logic [NUM_DIGITS-1:0] zero, lz_blank;
  logic [3:0] cur_bcd;
  logic [6:0] dec_seg;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  assign scan_tick = sync_2 & ~sync_3;
  assign wrap      = scan_tick && (index == 2'd3);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    index_next = index;
    if (scan_tick) begin
      index_next = index + 2'd1;
      if (BLANK_CYCLES == 0) begin
        state_next = ST_DRIVE;
        cnt_next   = '0;
      end else begin
        state_next = ST_BLANK;
        cnt_next   = CNT_W'(BLANK_CYCLES);
      end
    end else if (state == ST_BLANK && cnt != '0) begin
      // A zero count in BLANK is the post-reset idle; only a live count ends in DRIVE.
      cnt_next = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state_next = ST_DRIVE;
    end
  end

  // Outputs are built from the next-cycle view so they register in step with the state.
  assign digits_next  = wrap ? digits_bcd : shadow_digits;
  assign dp_mask_next = wrap ? dp_mask : shadow_dp;
  assign lz_next      = wrap ? blank_lz : shadow_lz;

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) zero[k] = (digits_next[k] == 4'd0);
    lz_blank[3] = lz_next & zero[3];
    lz_blank[2] = lz_next & zero[3] & zero[2];
    lz_blank[1] = lz_next & zero[3] & zero[2] & zero[1];
    lz_blank[0] = 1'b0;
  end

  assign cur_bcd = digits_next[index_next];

  seven_seg_decoder u_decoder (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (state_next == ST_DRIVE) begin
      an_next  = ~(4'b0001 << index_next);
      seg_next = lz_blank[index_next] ? SEG_OFF : dec_seg;
      dp_next  = ~dp_mask_next[index_next];
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      sync_1        <= 1'b0;
      sync_2        <= 1'b0;
      sync_3        <= 1'b0;
      state         <= ST_BLANK;
      cnt           <= '0;
      index         <= 2'd3;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_lz     <= 1'b0;
      an            <= 4'b1111;
      seg           <= SEG_OFF;
      dp            <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      sync_1        <= clk_1kHz;
      sync_2        <= sync_1;
      sync_3        <= sync_2;
      state         <= state_next;
      cnt           <= cnt_next;
      index         <= index_next;
      shadow_digits <= digits_next;
      shadow_dp     <= dp_mask_next;
      shadow_lz     <= lz_next;
      an            <= an_next;
      seg           <= seg_next;
      dp            <= dp_next;
      frame_done    <= wrap;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux: edge-exact timing after reset plus a
// scoreboard of per-digit drive snapshots {an,seg,dp} compared frame by frame.
module tb_score_display_mux;

  logic        clk_fpga = 1'b0;
  logic        reset = 1'b1;
  logic        clk_1kHz;
  logic [15:0] digits_bcd = 16'h0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  logic scan_run = 1'b0;
  logic manual_level = 1'b0;
  logic gen_level = 1'b0;
  int   gen_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;

  typedef logic [11:0] obs_t;   // {an, seg, dp}
  obs_t obs_q[$];
  obs_t exp_q[$];
  logic [3:0] prev_an = 4'b1111;

  assign clk_1kHz = scan_run ? gen_level : manual_level;

  score_display_mux #(.BLANK_CYCLES(4)) dut (
    .clk_fpga   (clk_fpga),
    .reset      (reset),
    .clk_1kHz   (clk_1kHz),
    .digits_bcd (digits_bcd),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk_fpga = ~clk_fpga;

  initial begin
    forever begin
      @(negedge clk_fpga);
      if (gen_cnt == 49) begin
        gen_cnt = 0;
        gen_level = ~gen_level;
      end else begin
        gen_cnt++;
      end
    end
  end

  // Record the first cycle of every digit drive.
  always @(negedge clk_fpga) begin
    if (an != 4'b1111 && prev_an == 4'b1111) obs_q.push_back({an, seg, dp});
    prev_an <= an;
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] d, input logic [3:0] m, input logic lz);
    logic [3:0] nib;
    logic       blank;
    logic [3:0] an_e;
    for (int k = 0; k < 4; k++) begin
      nib = d[k*4 +: 4];
      blank = lz && (k > 0);
      for (int j = k; j < 4; j++) if (d[j*4 +: 4] != 4'd0) blank = 1'b0;
      an_e = 4'b1111;
      an_e[k] = 1'b0;
      exp_q.push_back({an_e, blank ? 7'b1111111 : ref_seg(nib), ~m[k]});
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_fpga);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_obs(input int base, input int need, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (obs_q.size() >= base + need) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_fpga);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    scan_run = 1'b0;
    manual_level = 1'b0;
    repeat (3) @(negedge clk_fpga);
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_checks++;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_first_tick;
    digits_bcd = 16'h1234;
    dp_mask = 4'b0000;
    blank_lz = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk_fpga);
    manual_level = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk_fpga);
      #1;
      n_checks++;
      if (frame_done !== (e == 3)) begin
        n_fail++;
        $display("FAIL first_tick_frame_done edge %0d: got %b want %b", e, frame_done, (e == 3));
      end
      n_checks++;
      if (an !== ((e >= 7) ? 4'b1110 : 4'b1111)) begin
        n_fail++;
        $display("FAIL first_tick_an edge %0d: got %b want %b", e, an, (e >= 7) ? 4'b1110 : 4'b1111);
      end
    end
    n_checks++;
    if (seg !== 7'b0011001) begin n_fail++; $display("FAIL first_tick_seg: got %b want 0011001", seg); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL first_tick_dp: got %b want 1", dp); end
  endtask

  task automatic test_leading_zero;
    logic [15:0] pd [4] = '{16'h0045, 16'h0045, 16'h0000, 16'h0100};
    logic        pl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit ok;
    int base;
    obs_t got, want;
    scan_run = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk_fpga);
      digits_bcd = pd[p];
      dp_mask = 4'b0000;
      blank_lz = pl[p];
      wait_frame(ok);
      base = obs_q.size();
      push_frame(pd[p], 4'b0000, pl[p]);
      if (ok) wait_obs(base, 4, ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL lz_timeout pattern %0d: got no frame want 4 digit drives", p);
        exp_q.delete();
      end else begin
        for (int k = 0; k < 4; k++) begin
          got = obs_q[base + k];
          want = exp_q.pop_front();
          n_checks++;
          if (got !== want) begin
            n_fail++;
            $display("FAIL lz pattern %0d digit %0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                     p, k, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
          end
        end
      end
    end
  endtask

  task automatic test_dash_dp;
    bit ok;
    int base;
    obs_t got, want;
    @(negedge clk_fpga);
    digits_bcd = 16'hA000;
    dp_mask = 4'b1000;
    blank_lz = 1'b0;
    wait_frame(ok);
    base = obs_q.size();
    push_frame(16'hA000, 4'b1000, 1'b0);
    if (ok) wait_obs(base, 4, ok);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL dash_dp_timeout: got no frame want 4 digit drives");
      exp_q.delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        got = obs_q[base + k];
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL dash_dp digit %0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   k, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
        end
      end
    end
  endtask

  task automatic test_snapshot;
    bit ok;
    int base;
    obs_t got, want;
    @(negedge clk_fpga);
    digits_bcd = 16'h1111;
    dp_mask = 4'b0000;
    blank_lz = 1'b0;
    wait_frame(ok);
    base = obs_q.size();
    push_frame(16'h1111, 4'b0000, 1'b0);
    push_frame(16'h2222, 4'b0000, 1'b0);
    if (ok) wait_obs(base, 2, ok);
    digits_bcd = 16'h2222;
    if (ok) wait_obs(base, 8, ok);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL snapshot_timeout: got too few drives want 8");
      exp_q.delete();
    end else begin
      for (int k = 0; k < 8; k++) begin
        got = obs_q[base + k];
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL snapshot drive %0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   k, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drive;
    bit ok;
    @(negedge clk_fpga);
    digits_bcd = 16'h1234;
    dp_mask = 4'b0100;
    blank_lz = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_fpga);
      if (an == 4'b1011) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_drive_reach: got an=%b want 1011 within budget", an); end
    reset = 1'b1;
    scan_run = 1'b0;
    manual_level = 1'b1;
    @(posedge clk_fpga);
    #1;
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL mid_reset_an: got %b want 1111", an); end
    n_checks++;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL mid_reset_seg: got %b want 1111111", seg); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL mid_reset_dp: got %b want 1", dp); end
    repeat (2) @(negedge clk_fpga);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk_fpga);
      #1;
      n_checks++;
      if (frame_done !== (e == 3)) begin
        n_fail++;
        $display("FAIL post_reset_frame_done edge %0d: got %b want %b", e, frame_done, (e == 3));
      end
      n_checks++;
      if (an !== ((e >= 7) ? 4'b1110 : 4'b1111)) begin
        n_fail++;
        $display("FAIL post_reset_an edge %0d: got %b want %b", e, an, (e >= 7) ? 4'b1110 : 4'b1111);
      end
    end
    n_checks++;
    if (seg !== 7'b0011001) begin n_fail++; $display("FAIL post_reset_seg: got %b want 0011001", seg); end
  endtask

  initial begin
    test_reset;
    test_first_tick;
    test_leading_zero;
    test_dash_dp;
    test_snapshot;
    test_reset_mid_drive;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_mux.md
SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

Interface
REQ-001 The block SHALL have parameter BLANK_CYCLES, default 2000, the anode-off guard time in clk_fpga cycles after each digit change (ghosting suppression).
REQ-002 The block SHALL have port clk_fpga  input  1  100 MHz master clock, the only clock.
REQ-003 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port clk_1kHz  input  1  divided scan clock, sampled as data and never used as a clock.
REQ-005 The block SHALL have port digits_bcd  input  16  four BCD digits; [3:0] is rightmost (digit 0), [15:12] is leftmost (digit 3).
REQ-006 The block SHALL have port dp_mask  input  4  decimal point request per digit, bit i for digit i.
REQ-007 The block SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 The block SHALL have port an  output  4  active-low digit anodes; an[i] drives digit i.
REQ-009 The block SHALL have port seg  output  7  active-low cathodes, order {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dp  output  1  active-low decimal point.
REQ-011 The block SHALL have port frame_done  output  1  one-cycle pulse at each new-frame snapshot.

Function
REQ-012 The block SHALL pass clk_1kHz through a two-flop synchronizer, then a rising-edge detector producing scan_tick; the digit advance SHALL occur on the 3rd clk_fpga edge after clk_1kHz is first sampled high.
REQ-013 The block SHALL keep a 2-bit digit index; on each scan_tick the index SHALL advance modulo 4 (3 wraps to 0).
REQ-014 On a scan_tick that wraps the index to 0, the block SHALL latch digits_bcd, dp_mask and blank_lz into shadow registers and pulse frame_done for exactly that cycle; all display decoding SHALL use the shadow registers only.
REQ-015 The FSM SHALL have states BLANK and DRIVE: on scan_tick, go to BLANK with a counter loaded with BLANK_CYCLES; in BLANK, an=4'b1111; when the counter reaches 0, go to DRIVE; in DRIVE, an has only bit [index] low.
REQ-016 With BLANK_CYCLES=0, scan_tick SHALL go directly to DRIVE on the same edge.
REQ-017 A scan_tick arriving while in BLANK SHALL advance the index and reload the counter (the blank restarts).
REQ-018 Decoding SHALL use these seg values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10-15 SHALL show a dash, 0111111.
REQ-019 When the shadow blank_lz=1, digit k (k=3,2,1) SHALL show seg=1111111 if it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-020 In DRIVE, dp SHALL equal ~shadow_dp_mask[index], independent of blanking; in BLANK, dp=1 and seg=1111111.
REQ-021 an, seg and dp SHALL all be registered outputs; there SHALL be no combinational path from any input to any output.

Reset
REQ-022 While reset=1 at a clk_fpga edge, the block SHALL set: an=4'b1111, seg=7'b1111111, dp=1, frame_done=0, state=BLANK, blank counter=0, index=3, shadow registers=0, synchronizer and edge flops=0.
REQ-023 After reset release, the display SHALL stay dark until the first scan_tick, which wraps the index to 0 and takes a snapshot; if clk_1kHz is already high, that tick SHALL fire on the 3rd edge after release.
REQ-024 A reset asserted mid-frame or mid-blank SHALL take effect on the next edge, with no partial digit drive.

Structure
REQ-025 A shared package score_pkg SHALL hold the segment pattern constants, the dash pattern, the FSM state encoding and NUM_DIGITS=4.
REQ-026 The BCD-to-segment decode SHALL be the combinational sub-module seven_seg_decoder (4-bit in, 7-bit out); the FSM, counters and synchronizer SHALL stay in score_display_mux.

Verification
REQ-027 The bench SHALL use BLANK_CYCLES=4 and clk_1kHz toggling every 50 clk_fpga cycles.
REQ-028 Reset, then digits_bcd=16'h1234: first tick gives an=1111 for 4 cycles, then an=1110 with seg=0011001 (4), plus a frame_done pulse on the tick edge.
REQ-029 digits_bcd=16'h0045, blank_lz=1: digits 3 and 2 show seg=1111111, digit 1 shows 0011001 and digit 0 shows 0010010; with blank_lz=0, digits 3 and 2 show 1000000.
REQ-030 Change digits_bcd from 16'h1111 to 16'h2222 while index=1: digits 2 and 3 still show 1, and 2 appears only after the next frame_done.
REQ-031 digits_bcd=16'hA000, dp_mask=4'b1000: digit 3 shows seg=0111111 with dp=0, and all other digits have dp=1.
REQ-032 Assert reset during DRIVE of digit 2: on the next edge an=1111, seg=1111111 and dp=1; after release, clk_1kHz high produces a tick on the 3rd edge and the index becomes 0.
